// File: rtl/cla_bist_engine.sv
// Built-in self-test engine for the carry-lookahead adder: drives LFSR operand
// pairs, checks each sum/carry against a golden add, and reports the run result.

module cla_bist_golden #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             mismatch
);
  logic [WIDTH:0] exp_sum;

  assign exp_sum  = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  assign mismatch = ({dut_cout, dut_sum} != exp_sum);
endmodule

module cla_bist_engine #(
  parameter int                   WIDTH       = 8,
  parameter int                   NUM_VECTORS = 255,
  parameter logic [2*WIDTH-1:0]   SEED        = 16'hACE1,
  parameter logic [2*WIDTH-1:0]   TAPS        = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_fail_idx
);
  localparam int LW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] lfsr;
  logic [LW-1:0] lfsr_nxt;
  logic [7:0]    idx;
  logic [7:0]    idx_nxt;
  logic          mismatch;
  logic          last_vec;

  // Galois step: shift right, fold the taps back in when a one falls out
  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign idx_nxt  = idx + 8'd1;
  assign last_vec = (idx == 8'(NUM_VECTORS - 1));
  assign pass     = done && (err_count == 8'd0);

  cla_bist_golden #(.WIDTH(WIDTH)) u_golden (
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .dut_sum  (dut_sum),
    .dut_cout (dut_cout),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lfsr           <= SEED;
      idx            <= 8'd0;
      op_a           <= '0;
      op_b           <= '0;
      cin            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= 8'd0;
      first_fail_idx <= 8'd0;
    end else if (ena) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr           <= SEED;
            idx            <= 8'd0;
            err_count      <= 8'd0;
            first_fail_idx <= 8'd0;
            done           <= 1'b0;
            op_a           <= SEED[LW-1:WIDTH];
            op_b           <= SEED[WIDTH-1:0];
            cin            <= 1'b0;
            busy           <= 1'b1;
            state          <= S_DRIVE;
          end
        end
        // one idle cycle so the combinational adder output settles
        S_DRIVE: state <= S_CHECK;
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 8'd1;
            if (err_count == 8'd0) first_fail_idx <= idx;
          end
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            op_a  <= '0;
            op_b  <= '0;
            cin   <= 1'b0;
            state <= S_DONE;
          end else begin
            lfsr  <= lfsr_nxt;
            idx   <= idx_nxt;
            op_a  <= lfsr_nxt[LW-1:WIDTH];
            op_b  <= lfsr_nxt[WIDTH-1:0];
            cin   <= idx_nxt[0];
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_bist_engine.sv
// Scoreboard bench for cla_bist_engine with a behavioural adder that can be
// made ideal, bit0-stuck or inverted.

module tb_cla_bist_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op_a, op_b, dut_sum, err_count, first_fail_idx;
  logic       cin, dut_cout, busy, done, pass;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mode = 0;

  typedef struct {
    int err;
    int ffi;
    int pas;
    int lat;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] va[255];
  logic [7:0] vb[255];
  logic       vc[255];
  int         n_odd, first_odd;

  cla_bist_engine dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // behavioural adder under test
  always_comb begin
    logic [8:0] s;
    s = {1'b0, op_a} + {1'b0, op_b} + {8'd0, cin};
    {dut_cout, dut_sum} = s;
    if (mode == 1) {dut_cout, dut_sum} = s & 9'h1FE;
    else if (mode == 2) {dut_cout, dut_sum} = ~s;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // monitor: pops an expected result each time done rises
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_err_count", int'(err_count), e.err);
        if (e.err != 0) chk("res_first_fail_idx", int'(first_fail_idx), e.ffi);
        chk("res_pass", int'(pass), e.pas);
        chk("res_busy", int'(busy), 0);
        chk("res_latency", cyc - start_cyc, e.lat);
      end
    end
    done_prev = done;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic push_exp(input int err, input int ffi, input int pas, input int lat);
    exp_t e;
    e.err = err; e.ffi = ffi; e.pas = pas; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_a"}, int'(op_a), 0);
    chk({tag, "_op_b"}, int'(op_b), 0);
    chk({tag, "_cin"}, int'(cin), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_first_fail_idx"}, int'(first_fail_idx), 0);
  endtask

  initial begin
    // reference operand sequence and bit0-stuck expectations
    logic [15:0] l;
    logic [8:0]  s;
    l = 16'hACE1;
    n_odd = 0;
    first_odd = -1;
    for (int i = 0; i < 255; i++) begin
      va[i] = l[15:8];
      vb[i] = l[7:0];
      vc[i] = i[0];
      s = {1'b0, va[i]} + {1'b0, vb[i]} + {8'd0, vc[i]};
      if (s[0]) begin
        n_odd++;
        if (first_odd < 0) first_odd = i;
      end
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end

    // 1: reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 2: ideal adder, full operand sequence and 510-cycle run
    mode = 0;
    push_exp(0, 0, 1, 510);
    pulse_start();
    chk("s2_op_a0", int'(op_a), 8'hAC);
    chk("s2_op_b0", int'(op_b), 8'hE1);
    chk("s2_cin0", int'(cin), 0);
    chk("s2_busy", int'(busy), 1);
    for (int i = 0; i < 255; i++) begin
      if (op_a != va[i] || op_b != vb[i] || cin != vc[i]) begin
        chk("s2_vec_ops", {op_a, op_b, 7'd0, cin}, {va[i], vb[i], 7'd0, vc[i]});
        break;
      end
      repeat (2) @(negedge clk);
    end
    checks++;
    wait_done(20);
    chk("s2_ops_zero_after_done", int'({op_a, op_b, cin}), 0);

    // 3: sum bit0 stuck-at-0
    mode = 1;
    push_exp(n_odd, first_odd, 0, 510);
    pulse_start();
    wait_done(600);

    // 4: inverted adder output
    mode = 2;
    push_exp(255, 0, 0, 510);
    pulse_start();
    wait_done(600);

    // 5: 10-cycle ena stall at vector 7
    mode = 0;
    push_exp(0, 0, 1, 520);
    pulse_start();
    repeat (14) @(negedge clk);
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("s5_frozen_op_a", int'(op_a), int'(va[7]));
      chk("s5_frozen_op_b", int'(op_b), int'(vb[7]));
      chk("s5_frozen_cin", int'(cin), int'(vc[7]));
      chk("s5_frozen_busy", int'(busy), 1);
      chk("s5_frozen_err", int'(err_count), 0);
      @(negedge clk);
    end
    ena = 1'b1;
    chk("s5_resume_op_a", int'(op_a), int'(va[7]));
    @(negedge clk);
    @(negedge clk);
    chk("s5_next_op_a", int'(op_a), int'(va[8]));
    wait_done(600);

    // 6: async reset mid-run, then a clean rerun
    mode = 2;
    pulse_start();
    repeat (200) @(negedge clk);
    chk("s6_vec100_op_a", int'(op_a), int'(va[100]));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("s6_async");
    @(negedge clk);
    chk_reset_outputs("s6_held");
    rst_n = 1'b1;
    mode = 0;
    @(negedge clk);
    push_exp(0, 0, 1, 510);
    pulse_start();
    chk("s6_rerun_op_a", int'(op_a), 8'hAC);
    chk("s6_rerun_op_b", int'(op_b), 8'hE1);
    wait_done(600);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
